// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient bus: state encoding,
// coefficient slice mapping and index sizing.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // LSB of tap i inside the concatenated coefs vector; tap 0 sits on top.
  function automatic int coef_lsb(input int i, input int cwidth, input int taps);
    return (taps - 1 - i) * cwidth;
  endfunction

  // Width of the tap index register, never narrower than one bit.
  function automatic int idx_w(input int taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Loads a coefficient frame into a shadow bank and commits it atomically
// to the active set only when the frame carries exactly TAPS words.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int CWIDTH = 16,
  parameter int TAPS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CWIDTH-1:0]        s_data,
  input  logic                     s_last,
  output logic [TAPS*CWIDTH-1:0]   coefs,
  output logic                     coef_update,
  output logic                     err_short,
  output logic                     err_long,
  output logic                     busy
);

  localparam int IW = idx_w(TAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  state_t            state, state_next;
  logic [IW-1:0]     index, index_next;
  logic [IW-1:0]     wr_idx;
  logic              wr_en;
  logic              short_next, long_next;
  logic              accept;
  logic [CWIDTH-1:0] shadow [TAPS];

  assign accept = s_valid & s_ready;
  assign busy   = (state != IDLE);

  // Next-state, shadow write strobe and error pulse decode.
  always_comb begin
    state_next = state;
    index_next = index;
    wr_idx     = index;
    wr_en      = 1'b0;
    short_next = 1'b0;
    long_next  = 1'b0;
    case (state)
      IDLE: begin
        wr_idx = '0;
        if (accept) begin
          wr_en = 1'b1;
          if (TAPS == 1) begin
            if (s_last) state_next = COMMIT;
            else begin
              long_next  = 1'b1;
              state_next = DRAIN;
            end
          end else if (s_last) begin
            // One-word frame on a multi-tap build: too short, stay put.
            short_next = 1'b1;
          end else begin
            state_next = LOAD;
            index_next = IW'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (index == LAST_IDX) begin
            if (s_last) state_next = COMMIT;
            else begin
              long_next  = 1'b1;
              state_next = DRAIN;
              index_next = '0;
            end
          end else if (s_last) begin
            short_next = 1'b1;
            state_next = IDLE;
            index_next = '0;
          end else begin
            index_next = index + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_next = IDLE;
        index_next = '0;
      end
      DRAIN: begin
        if (accept && s_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, index, registered ready and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= '0;
      s_ready     <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      coef_update <= 1'b0;
    end else begin
      state       <= state_next;
      index       <= index_next;
      s_ready     <= (state_next != COMMIT);
      err_short   <= short_next;
      err_long    <= long_next;
      coef_update <= (state == COMMIT);
    end
  end

  // Shadow bank capture; content after an error is simply overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < TAPS; i++)
        if (wr_idx == IW'(i)) shadow[i] <= s_data;
    end
  end

  // Active set: whole shadow bank copied in the single COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      coefs <= '0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < TAPS; i++)
        coefs[coef_lsb(i, CWIDTH, TAPS) +: CWIDTH] <= shadow[i];
    end
  end

endmodule
